mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the MIPS pipeline, sitting between the EX/MEM latch and the register-file writeback. It consumes the EX/MEM latch outputs (control, ALU result, store data, destination register, branch target, zero). It runs load/store accesses over a req/ack data-memory bus, stalling upstream stages while an access is outstanding. It registers results into an internal MEM/WB latch and resolves the branch decision (`pcsrc`) for the fetch stage.

## Interface
- `DW`, default 32: data and address width.
- `TIMEOUT`, default 16: cycles allowed in WAIT before abort (used only with the timeout feature).
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wb_in` in 2: writeback control. [1] is regwrite, [0] is memtoreg.
- `branch`, `memread`, `memwrite` in 1 each: EX/MEM memory controls.
- `zero_in` in 1: ALU zero flag.
- `target_in` in DW: branch target address.
- `addr_in` in DW: ALU result, used as both memory address and ALU passthrough.
- `wdata_in` in DW: store data.
- `dest_in` in 5: destination register.
- `pcsrc` out 1: `branch & zero_in`, combinational.
- `branch_target` out DW: equals `target_in`.
- `stall` out 1: hold PC, IF/ID, ID/EX and EX/MEM.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out DW, `dmem_wdata` out DW: data-memory request.
- `dmem_ack` in 1, `dmem_rdata` in DW: data-memory response.
- `wb_out` out 2, `rdata_out` out DW, `alu_out` out DW, `dest_out` out 5: MEM/WB latch.
- `bus_err` out 1: access aborted by timeout.

## Operation
- FSM states are IDLE and WAIT.
- A mem op is `memread | memwrite`. When both are set, the write wins.
- **IDLE, no mem op:** `stall`=0. The MEM/WB latch loads `wb_in`, `addr_in` and `dest_in`, with `rdata_out`=0.
- **IDLE, mem op:**
  - `stall`=1, combinational.
  - At the next edge: go to WAIT; set `dmem_req`=1; set `dmem_we`=`memwrite`; capture `addr_in` into `dmem_addr` and `wdata_in` into `dmem_wdata`.
  - The MEM/WB latch loads a bubble: all fields 0.
- **WAIT, `dmem_ack`=0:**
  - `stall`=1. `dmem_*` outputs are held stable.
  - The MEM/WB latch loads a bubble.
- **WAIT, `dmem_ack`=1:**
  - `stall`=0, so EX/MEM advances at this edge.
  - At the edge: the MEM/WB latch loads `wb_in`, `addr_in` and `dest_in`. `rdata_out` gets `dmem_rdata` for a load, 0 for a store.
  - Also at the edge: `dmem_req` goes to 0 and the FSM returns to IDLE.
- `dmem_ack` in IDLE is ignored.
- `stall` = (IDLE & memop) | (WAIT & ~ack).
- `pcsrc` is purely combinational and independent of the FSM. The fetch stage qualifies it with `stall`.

## Timing
- Reset at any time, including mid-access: at the next edge the state goes to IDLE and every registered output (`dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `wb_out`, `rdata_out`, `alu_out`, `dest_out`, `bus_err`) goes to 0. A late ack after reset is ignored.
- Non-memory instruction: 1-cycle latency from EX/MEM to MEM/WB.
- Memory instruction: minimum 2 cycles (1 stall cycle) when ack arrives in the first WAIT cycle. Each additional wait cycle adds 1 stall cycle.
- `dmem_req` rises exactly one edge after the mem op is first seen in IDLE. It falls on the edge where ack is sampled.
- Back-to-back mem ops: IDLE for one cycle between accesses, so minimum throughput is one access per 2 cycles.

## Configuration
- Macro `MEM_STAGE_TIMEOUT_EN`.
- **Defined:**
  - A counter counts WAIT cycles.
  - If `TIMEOUT` cycles elapse with no ack, at that edge: `dmem_req`=0, FSM to IDLE, `stall` released in that cycle, `bus_err`=1 for exactly one cycle.
  - The MEM/WB latch loads the instruction with `wb_out[1]` forced 0 and `rdata_out`=0.
  - The counter clears on entering WAIT and on reset.
- **Undefined:** WAIT has no limit, no counter logic is generated, and `bus_err` is tied to 0.

## Structure
- Shared package `mips_pkg`:
  - FSM state typedef.
  - `WB_REGWRITE`=1, `WB_MEMTOREG`=0 bit indices.
  - `REG_ADDR_W`=5.
- Sub-module `mem_wb_latch`: synchronous-reset register for `wb_out`, `rdata_out`, `alu_out`, `dest_out`, with a `bubble` input that forces all fields to 0.
- FSM, bus drive and stall logic stay in `mem_stage`.

## Test plan
- **Reset mid-access:**
  - Stimulus: load to `0x40`, assert `rst` in WAIT, then ack the next cycle.
  - Required: `dmem_req`=0 and all outputs 0 after the reset edge; the ack is ignored.
- **Non-memory instruction:**
  - Stimulus: `wb_in`=2'b10, `addr_in`=`0x1234`, `dest_in`=5.
  - Required: one cycle later `wb_out`=2'b10, `alu_out`=`0x1234`, `dest_out`=5, and `stall` never rises.
- **Load with 3-cycle ack delay:**
  - Stimulus: load from `addr_in`=`0x100`, `dmem_rdata`=`0xDEADBEEF`.
  - Required: `stall` high for 3 cycles; `dmem_addr`=`0x100` stable while `dmem_req` is high; then `rdata_out`=`0xDEADBEEF` and `wb_out`=2'b11.
- **Store, then immediate load:**
  - Stimulus: store `0xCAFE` to `0x8`, then a load; ack is immediate for both.
  - Required: `dmem_we`=1 with `dmem_wdata`=`0xCAFE`, then one IDLE cycle, then the second request with `dmem_we`=0.
- **Branch:**
  - Stimulus: `branch`=1 with `zero_in`=1, then `branch`=1 with `zero_in`=0.
  - Required: `pcsrc`=1 and `branch_target`=`target_in` in the same cycle; then `pcsrc`=0.
- **Timeout (with `MEM_STAGE_TIMEOUT_EN`, `TIMEOUT`=4):**
  - Stimulus: load with no ack.
  - Required: `bus_err` pulses once after 4 WAIT cycles, `wb_out[1]`=0, and `stall` is released.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared pipeline types and constants for the memory stage
package mips_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int REG_ADDR_W  = 5;

endpackage

// File: rtl/mem_wb_latch.sv
// rtl/mem_wb_latch.sv - MEM/WB pipeline latch; bubble loads all-zero fields
module mem_wb_latch
  import mips_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bubble,
  input  logic [1:0]            wb_in,
  input  logic [DW-1:0]         rdata_in,
  input  logic [DW-1:0]         alu_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  output logic [1:0]            wb_out,
  output logic [DW-1:0]         rdata_out,
  output logic [DW-1:0]         alu_out,
  output logic [REG_ADDR_W-1:0] dest_out
);

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      wb_out    <= '0;
      rdata_out <= '0;
      alu_out   <= '0;
      dest_out  <= '0;
    end else begin
      wb_out    <= wb_in;
      rdata_out <= rdata_in;
      alu_out   <= alu_in;
      dest_out  <= dest_in;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage with req/ack data bus; optional MEM_STAGE_TIMEOUT_EN watchdog
module mem_stage
  import mips_pkg::*;
#(
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            wb_in,
  input  logic                  branch,
  input  logic                  memread,
  input  logic                  memwrite,
  input  logic                  zero_in,
  input  logic [DW-1:0]         target_in,
  input  logic [DW-1:0]         addr_in,
  input  logic [DW-1:0]         wdata_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  output logic                  pcsrc,
  output logic [DW-1:0]         branch_target,
  output logic                  stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DW-1:0]         dmem_addr,
  output logic [DW-1:0]         dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DW-1:0]         dmem_rdata,
  output logic [1:0]            wb_out,
  output logic [DW-1:0]         rdata_out,
  output logic [DW-1:0]         alu_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic                  bus_err
);

  mem_state_e    state_q, state_d;
  logic          memop;
  logic          timeout;
  logic          bubble;
  logic [1:0]    wb_lat;
  logic [DW-1:0] rdata_lat;

  assign memop         = memread | memwrite;
  assign pcsrc         = branch & zero_in;
  assign branch_target = target_in;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Held at zero while idle so every access starts its count fresh.
  always_ff @(posedge clk) begin
    if (rst || state_q == ST_IDLE) begin
      wait_cnt <= '0;
    end else if (!dmem_ack) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = (state_q == ST_WAIT) && !dmem_ack && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= timeout;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout        = 1'b0;
  assign bus_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    bubble  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (memop) begin
          stall   = 1'b1;
          state_d = ST_WAIT;
        end else begin
          bubble = 1'b0;
        end
      end
      ST_WAIT: begin
        if (dmem_ack || timeout) begin
          bubble  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wb_lat = wb_in;
    if (timeout) begin
      wb_lat[WB_REGWRITE] = 1'b0;
    end
    // Load data only returns on an acked read; stores and aborts write back zero.
    rdata_lat = (state_q == ST_WAIT && dmem_ack && !dmem_we) ? dmem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else if (state_q == ST_IDLE && memop) begin
      dmem_req   <= 1'b1;
      dmem_we    <= memwrite;
      dmem_addr  <= addr_in;
      dmem_wdata <= wdata_in;
    end else if (state_q == ST_WAIT && (dmem_ack || timeout)) begin
      dmem_req <= 1'b0;
    end
  end

  mem_wb_latch #(.DW(DW)) u_mem_wb_latch (
    .clk       (clk),
    .rst       (rst),
    .bubble    (bubble),
    .wb_in     (wb_lat),
    .rdata_in  (rdata_lat),
    .alu_in    (addr_in),
    .dest_in   (dest_in),
    .wb_out    (wb_out),
    .rdata_out (rdata_out),
    .alu_out   (alu_out),
    .dest_out  (dest_out)
  );

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    wb_in;
  logic          branch, memread, memwrite, zero_in;
  logic [DW-1:0] target_in, addr_in, wdata_in;
  logic [4:0]    dest_in;
  logic          pcsrc;
  logic [DW-1:0] branch_target;
  logic          stall;
  logic          dmem_req, dmem_we;
  logic [DW-1:0] dmem_addr, dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic [1:0]    wb_out;
  logic [DW-1:0] rdata_out, alu_out;
  logic [4:0]    dest_out;
  logic          bus_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.DW(DW), .TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_in         (wb_in),
    .branch        (branch),
    .memread       (memread),
    .memwrite      (memwrite),
    .zero_in       (zero_in),
    .target_in     (target_in),
    .addr_in       (addr_in),
    .wdata_in      (wdata_in),
    .dest_in       (dest_in),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .stall         (stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .wb_out        (wb_out),
    .rdata_out     (rdata_out),
    .alu_out       (alu_out),
    .dest_out      (dest_out),
    .bus_err       (bus_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_in = 2'b00; branch = 1'b0; memread = 1'b0; memwrite = 1'b0; zero_in = 1'b0;
    target_in = '0; addr_in = '0; wdata_in = '0; dest_in = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    chk("rst_req",   dmem_req,  1'b0);
    chk("rst_wb",    wb_out,    2'b00);
    chk("rst_alu",   alu_out,   32'h0);
    chk("rst_berr",  bus_err,   1'b0);
    rst = 1'b0;
    #1;
    chk("rst_stall", stall, 1'b0);

    // Non-memory instruction: one-cycle passthrough
    wb_in = 2'b10; addr_in = 32'h1234; dest_in = 5'd5;
    #1;
    chk("nm_stall0", stall, 1'b0);
    step();
    chk("nm_wb",     wb_out,    2'b10);
    chk("nm_alu",    alu_out,   32'h1234);
    chk("nm_dest",   dest_out,  5'd5);
    chk("nm_rdata",  rdata_out, 32'h0);
    chk("nm_stall1", stall,     1'b0);

    // Load with ack in the third WAIT cycle: three stall cycles
    wb_in = 2'b11; addr_in = 32'h100; dest_in = 5'd7; memread = 1'b1;
    #1;
    chk("ld_stall_c0", stall,    1'b1);
    chk("ld_req_c0",   dmem_req, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      step();
      chk("ld_stall_w", stall,     1'b1);
      chk("ld_req_w",   dmem_req,  1'b1);
      chk("ld_we_w",    dmem_we,   1'b0);
      chk("ld_addr_w",  dmem_addr, 32'h100);
      chk("ld_bubble",  wb_out,    2'b00);
    end
    step();
    chk("ld_addr_w3", dmem_addr, 32'h100);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_stall_ack", stall, 1'b0);
    step();
    chk("ld_req_done", dmem_req,  1'b0);
    chk("ld_rdata",    rdata_out, 32'hDEADBEEF);
    chk("ld_wb",       wb_out,    2'b11);
    chk("ld_dest",     dest_out,  5'd7);
    chk("ld_alu",      alu_out,   32'h100);
    idle_inputs();
    step();

    // Store then immediate load, each acked in the first WAIT cycle
    memwrite = 1'b1; addr_in = 32'h8; wdata_in = 32'hCAFE;
    #1;
    chk("st_stall", stall, 1'b1);
    step();
    chk("st_req",   dmem_req,   1'b1);
    chk("st_we",    dmem_we,    1'b1);
    chk("st_wdata", dmem_wdata, 32'hCAFE);
    chk("st_addr",  dmem_addr,  32'h8);
    dmem_ack = 1'b1; dmem_rdata = 32'h77;
    step();
    chk("st_req_done", dmem_req,  1'b0);
    chk("st_alu",      alu_out,   32'h8);
    chk("st_rdata",    rdata_out, 32'h0);
    memwrite = 1'b0; memread = 1'b1; addr_in = 32'h10; wb_in = 2'b11; dmem_ack = 1'b0;
    #1;
    chk("ld2_idle_req",   dmem_req, 1'b0);
    chk("ld2_idle_stall", stall,    1'b1);
    step();
    chk("ld2_req",  dmem_req,  1'b1);
    chk("ld2_we",   dmem_we,   1'b0);
    chk("ld2_addr", dmem_addr, 32'h10);
    dmem_ack = 1'b1; dmem_rdata = 32'h55;
    step();
    chk("ld2_req_done", dmem_req,  1'b0);
    chk("ld2_rdata",    rdata_out, 32'h55);
    idle_inputs();
    step();

    // Branch resolution is purely combinational
    branch = 1'b1; zero_in = 1'b1; target_in = 32'h400;
    #1;
    chk("br_taken",  pcsrc,         1'b1);
    chk("br_target", branch_target, 32'h400);
    zero_in = 1'b0;
    #1;
    chk("br_not_taken", pcsrc, 1'b0);
    idle_inputs();
    step();

    // Reset in the middle of an access; the late ack is ignored
    memread = 1'b1; addr_in = 32'h40; wb_in = 2'b11; dest_in = 5'd3;
    step();
    chk("mr_req_wait", dmem_req, 1'b1);
    rst = 1'b1;
    step();
    chk("mr_req",  dmem_req,  1'b0);
    chk("mr_addr", dmem_addr, 32'h0);
    chk("mr_wb",   wb_out,    2'b00);
    chk("mr_dest", dest_out,  5'd0);
    rst = 1'b0;
    idle_inputs();
    dmem_ack = 1'b1; dmem_rdata = 32'h99;
    #1;
    chk("mr_stall", stall, 1'b0);
    step();
    chk("mr_ack_req",   dmem_req,  1'b0);
    chk("mr_ack_rdata", rdata_out, 32'h0);
    idle_inputs();
    step();

`ifdef MEM_STAGE_TIMEOUT_EN
    memread = 1'b1; addr_in = 32'h200; wb_in = 2'b11; dest_in = 5'd9;
    step();
    for (int i = 1; i <= 3; i++) begin
      chk("to_stall_w", stall,   1'b1);
      chk("to_berr_w",  bus_err, 1'b0);
      step();
    end
    chk("to_stall_rel", stall, 1'b0);
    step();
    chk("to_berr",  bus_err,  1'b1);
    chk("to_req",   dmem_req, 1'b0);
    chk("to_wb",    wb_out,   2'b01);
    chk("to_rdata", rdata_out, 32'h0);
    idle_inputs();
    step();
    chk("to_berr_pulse", bus_err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
